reg_dump_unit: RTL and testbench
================================

# reg_dump_unit

Debug-path sequencer in the ID stage. It walks the register file debug read port from address 0 to 2**W-1 and captures each word. Each word is serialized MSB-byte-first into the UART transmitter through a start/done byte handshake. It is started by the debug controller while the pipeline is halted, and signals completion with a single-cycle done pulse.

## Interface
- B, 32, register width in bits; must be a multiple of 8
- W, 5, register address width; 2**W registers are dumped

- i_clk  in  1  system clock; all state updates on rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_start  in  1  dump request; sampled only in IDLE
- i_reg_data  in  B  register file debug read data (combinational from o_debug_addr)
- i_tx_done  in  1  UART byte-complete pulse; sampled only in WAIT
- o_debug_addr  out  W  register address driven to the register file debug port
- o_tx_data  out  8  byte for the UART transmitter
- o_tx_start  out  1  one-cycle request to transmit o_tx_data
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the last byte of register 2**W-1 is acknowledged

## Operation
- Internal state:
  - reg_idx (W bits)
  - byte_idx (clog2(B/8) bits, minimum 1)
  - shift_reg (B bits)
  - FSM: IDLE, SETUP, LOAD, SEND, WAIT, DONE
- Output assignments:
  - o_debug_addr = reg_idx at all times.
  - o_tx_data = shift_reg[B-1:B-8].
  - o_tx_start = (state==SEND).
  - o_done = (state==DONE).
- State transitions:
  - IDLE: if i_start, then reg_idx<=0, byte_idx<=0, go to SETUP.
  - SETUP: one settle cycle for the register file address path, then go to LOAD.
  - LOAD: shift_reg<=i_reg_data, go to SEND.
  - SEND: o_tx_start high for exactly one cycle, go to WAIT.
  - WAIT:
    - No i_tx_done: hold. shift_reg and o_tx_data stay stable.
    - i_tx_done and byte_idx<B/8-1: byte_idx++, shift_reg<<=8 (zero fill), go to SEND.
    - i_tx_done and byte_idx==B/8-1 and reg_idx<2**W-1: byte_idx<=0, reg_idx++, go to SETUP.
    - i_tx_done and byte_idx==B/8-1 and reg_idx==2**W-1: go to DONE.
  - DONE: one cycle, go to IDLE. reg_idx is left at 2**W-1; there is no wrap-around to 0 mid-dump.
- Ignored inputs:
  - i_start outside IDLE is ignored, including a held-high i_start; a new dump requires IDLE.
  - i_tx_done outside WAIT is ignored; it never advances byte_idx.
- Reset:
  - i_reset has priority over all transitions.
  - State returns to IDLE; reg_idx, byte_idx and shift_reg are cleared.
  - A partially sent dump is abandoned, not resumed.
  - If i_reset and i_start are high on the same edge, the result is IDLE with no dump.
- Total bytes per dump: 2**W * B/8, which is 128 for the defaults.

## Timing
- Reset values: o_debug_addr=0, o_tx_data=0x00, o_tx_start=0, o_busy=0, o_done=0.
- First byte:
  - i_start sampled at edge 0 enters SETUP.
  - Edge 1 enters LOAD.
  - Edge 2 captures the word and enters SEND.
  - o_tx_start is high between edges 2 and 3.
- Byte to byte: i_tx_done sampled at edge k puts o_tx_start high in cycle k..k+1, with the new byte valid in the same cycle.
- Register to register: i_tx_done on the last byte at edge k is followed by SETUP, then LOAD, then o_tx_start in cycle k+2..k+3.
- Register read:
  - o_debug_addr is stable for at least one full cycle (SETUP) before capture in LOAD.
  - Register file writes during a dump are outside the contract; the pipeline must be halted.
- o_busy rises the cycle after i_start is sampled and falls the cycle after DONE.
- o_done is coincident with the final cycle of o_busy.

## Test plan
- Reset mid-dump: assert i_reset while in WAIT on register 3, byte 2 -> next cycle all outputs 0 and IDLE; no further o_tx_start until a new i_start.
- Full dump with ideal UART (i_tx_done one cycle after each o_tx_start), regs[i]=0xA5000000+i -> 128 bytes in order A5,00,00,i per register; exactly one o_done after register 31 byte 3.
- Slow UART (i_tx_done 20 cycles after o_tx_start) -> o_tx_data and o_debug_addr hold stable for the whole wait; each o_tx_start is exactly 1 cycle wide.
- Spurious i_tx_done pulses in SETUP/LOAD/SEND and i_start held high throughout -> byte count is still 128; a single dump runs and no restart happens until IDLE.
- Register 31 = 0xDEADBEEF -> last four bytes DE,AD,BE,EF; o_done pulses the cycle after the EF acknowledge is sampled, then o_busy=0.

Source files
------------

// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_unit
//  Purpose  : Debug-path sequencer. Walks the register file debug read port
//             from address 0 to 2**W-1. Each captured word goes out to the
//             UART transmitter one byte at a time, most significant byte
//             first, using a start/done byte handshake. The debug controller
//             starts a dump while the pipeline is halted. Completion is
//             signalled by a single-cycle done pulse.
//  Ports    :
//    i_clk        in   1  system clock, rising edge
//    i_reset      in   1  synchronous, active-high reset
//    i_start      in   1  dump request, honoured only in IDLE
//    i_reg_data   in   B  register file debug read data (combinational)
//    i_tx_done    in   1  UART byte-complete pulse, honoured only in WAIT
//    o_debug_addr out  W  register file debug read address
//    o_tx_data    out  8  byte presented to the UART transmitter
//    o_tx_start   out  1  one-cycle transmit request
//    o_busy       out  1  high in every state except IDLE
//    o_done       out  1  one-cycle pulse after the final byte is acknowledged
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_unit #(
    parameter int B = 32,   // register width in bits, multiple of 8
    parameter int W = 5     // register address width
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [B-1:0] i_reg_data,
    input  logic         i_tx_done,
    output logic [W-1:0] o_debug_addr,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_start,
    output logic         o_busy,
    output logic         o_done
);

    localparam int NBYTES = B / 8;
    // Byte counter is at least one bit wide, even for single-byte registers.
    localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);
    localparam logic [W-1:0]   LAST_REG  = {W{1'b1}};

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]     state;
    logic [W-1:0]   reg_idx;
    logic [BIW-1:0] byte_idx;
    logic [B-1:0]   shift_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Abandons any dump in progress; a start on the same edge is lost.
            state     <= IDLE;
            reg_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        reg_idx  <= '0;
                        byte_idx <= '0;
                        state    <= SETUP;
                    end
                end
                // Address settles for a full cycle before the word is taken.
                SETUP: state <= LOAD;
                LOAD: begin
                    shift_reg <= i_reg_data;
                    state     <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (i_tx_done) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx  <= byte_idx + 1'b1;
                            shift_reg <= shift_reg << 8;
                            state     <= SEND;
                        end else if (reg_idx != LAST_REG) begin
                            byte_idx <= '0;
                            reg_idx  <= reg_idx + 1'b1;
                            state    <= SETUP;
                        end else begin
                            // reg_idx stays at the last address; no wrap.
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_debug_addr = reg_idx;
    assign o_tx_data    = shift_reg[B-1 -: 8];
    assign o_tx_start   = (state == SEND);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_unit
//  Purpose  : Directed self-checking bench for reg_dump_unit. A behavioural
//             register file feeds the debug read port. A UART model
//             acknowledges each byte after a programmable delay.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;

    localparam int B = 32;
    localparam int W = 5;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [B-1:0] i_reg_data;
    logic         i_tx_done;
    logic [W-1:0] o_debug_addr;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic         o_busy;
    logic         o_done;

    logic [B-1:0] regs [2**W];

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    assign i_reg_data = regs[o_debug_addr];

    reg_dump_unit #(.B(B), .W(W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_reg_data   (i_reg_data),
        .i_tx_done    (i_tx_done),
        .o_debug_addr (o_debug_addr),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte n of the dump: register n/4, most significant byte first.
    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        if (n >= 128) return 8'hxx;
        w = regs[n / 4];
        return w[31 - 8 * (n % 4) -: 8];
    endfunction

    // Runs one dump. delay = cycles in WAIT before the ack pulse.
    // noisy drives random i_tx_done outside WAIT; hold_start keeps i_start
    // high until done. abort_at >= 0 resets while waiting on that byte.
    task automatic run_dump(input int delay, input bit noisy, input bit hold_start,
                            input int abort_at, input bit check_tail);
        int         cnt;
        int         nbytes;
        int         ndone;
        bit         done_seen;
        bit         finished;
        logic [7:0] held_data;
        logic [4:0] held_addr;
        logic [7:0] tail [4];
        cnt = -1; nbytes = 0; ndone = 0; done_seen = 0; finished = 0;
        held_data = 8'h00; held_addr = 5'd0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        if (!hold_start) i_start = 1'b0;
        check("busy_rise", o_busy, 1);
        check("setup_addr", o_debug_addr, 0);
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            i_tx_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done_seen) begin
                check("busy_fall", o_busy, 0);
                finished = 1;
            end else begin
                if (o_done) begin
                    ndone++;
                    done_seen = 1;
                    i_start   = 1'b0;
                    check("done_bytes", nbytes, 128);
                    check("done_busy", o_busy, 1);
                    if (check_tail) begin
                        check("tail0", tail[0], 8'hDE);
                        check("tail1", tail[1], 8'hAD);
                        check("tail2", tail[2], 8'hBE);
                        check("tail3", tail[3], 8'hEF);
                    end
                end
                if (o_tx_start) begin
                    check("byte", o_tx_data, exp_byte(nbytes));
                    check("addr", o_debug_addr, nbytes / 4);
                    held_data = o_tx_data;
                    held_addr = o_debug_addr;
                    tail[nbytes % 4] = o_tx_data;
                    nbytes++;
                    cnt = delay;
                end else if (cnt > 0) begin
                    check("hold_data", o_tx_data, held_data);
                    check("hold_addr", o_debug_addr, held_addr);
                    if (abort_at >= 0 && nbytes == abort_at + 1) begin
                        i_tx_done = 1'b0;
                        i_reset   = 1'b1;
                        @(negedge i_clk);
                        i_reset = 1'b0;
                        check("abort_addr", o_debug_addr, 0);
                        check("abort_data", o_tx_data, 0);
                        check("abort_start", o_tx_start, 0);
                        check("abort_busy", o_busy, 0);
                        check("abort_done", o_done, 0);
                        for (int k = 0; k < 30; k++) begin
                            @(negedge i_clk);
                            check("abort_quiet", {o_tx_start, o_busy, o_done}, 0);
                        end
                        return;
                    end
                    cnt--;
                    i_tx_done = (cnt == 0);
                end else if (cnt == 0) begin
                    if (nbytes == 128) check("done_timing", o_done, 1);
                    cnt = -1;
                end
            end
            @(negedge i_clk);
        end
        i_tx_done = 1'b0;
        check("finished", finished, 1);
        check("done_count", ndone, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            check("post_quiet", {o_tx_start, o_busy, o_done}, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**W; i++) regs[i] = 32'hA500_0000 + i;
        i_reset = 1'b1; i_start = 1'b0; i_tx_done = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_addr", o_debug_addr, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_start", o_tx_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);

        // Reset and start on the same edge: stays idle.
        i_reset = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        check("rst_start_busy", o_busy, 0);
        i_reset = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        check("rst_start_idle", o_busy, 0);

        run_dump(1, 1'b0, 1'b0, -1, 1'b0);   // ideal UART
        run_dump(20, 1'b0, 1'b0, -1, 1'b0);  // slow UART
        regs[31] = 32'hDEAD_BEEF;
        run_dump(1, 1'b1, 1'b1, -1, 1'b1);   // spurious acks, held start
        run_dump(3, 1'b0, 1'b0, 14, 1'b0);   // reset on reg 3 byte 2

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
